// File: rtl/n64a_vconv_modectrl_if.sv
// Mode-control bus between the config/OSD side and n64a_vconv_modectrl.
// Carries the raw mode request and sync nibble in, and the switched mode and blanking out.
interface n64a_vconv_modectrl_if;
    logic       nYPbPr_req;
    logic [3:0] S_i;
    logic       nEN_YPbPr_o;
    logic       blank_o;
    logic       busy_o;
    logic       chg_pulse_o;

    modport master (
        output nYPbPr_req, S_i,
        input  nEN_YPbPr_o, blank_o, busy_o, chg_pulse_o
    );

    modport slave (
        input  nYPbPr_req, S_i,
        output nEN_YPbPr_o, blank_o, busy_o, chg_pulse_o
    );
endinterface

// File: rtl/n64a_vconv_modectrl.sv
// RGB<->YPbPr mode sequencer: waits for vsync, blanks while the conversion pipe
// flushes, flips nEN_YPbPr, then holds blank for a settle window and POST_FRAMES frames.
module n64a_vconv_modectrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FLUSH_CYC   = 4,
    parameter int POST_FRAMES = 1,
    parameter int TO_W        = 21
) (
    input  logic                   VCLK,
    input  logic                   nRST,
    n64a_vconv_modectrl_if.slave   bus
);
    localparam int              CNT_W    = $clog2(FLUSH_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYC - 1);
    localparam logic [1:0]      FRM_LAST = (POST_FRAMES == 0) ? 2'd0 : 2'(POST_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, ARM, FLUSH, SWITCH, POST} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   vsync_q;
    logic [TO_W-1:0]        to_q, to_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             frm_q, frm_d;
    logic                   wait_q, wait_d;
    logic                   mode_q, mode_d;
    logic                   chg_q, chg_d;
    logic                   blank_q, blank_d;
    logic                   busy_q, busy_d;
    logic                   req_s, vs_fall;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign vs_fall = vsync_q & ~bus.S_i[3];

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            sync_q  <= '1;
            vsync_q <= 1'b1;
            state_q <= IDLE;
            to_q    <= '0;
            cnt_q   <= '0;
            frm_q   <= '0;
            wait_q  <= 1'b0;
            mode_q  <= 1'b1;
            chg_q   <= 1'b0;
            blank_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= (sync_q << 1) | SYNC_STAGES'(bus.nYPbPr_req);
            vsync_q <= bus.S_i[3];
            state_q <= state_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            frm_q   <= frm_d;
            wait_q  <= wait_d;
            mode_q  <= mode_d;
            chg_q   <= chg_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        frm_d   = frm_q;
        wait_d  = wait_q;
        mode_d  = mode_q;
        chg_d   = 1'b0;
        case (state_q)
            IDLE: begin
                to_d = '0;
                if (req_s != mode_q) state_d = ARM;
            end
            ARM: begin
                // A timeout and a vsync edge in the same cycle still give one transition.
                if (req_s == mode_q) begin
                    state_d = IDLE;
                end else if (vs_fall || (&to_q)) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_LAST) begin
                    // Mode output is set up one cycle early so it lands in SWITCH with the pulse.
                    state_d = SWITCH;
                    mode_d  = req_s;
                    chg_d   = (req_s != mode_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SWITCH: begin
                state_d = POST;
                cnt_d   = '0;
                frm_d   = '0;
                wait_d  = 1'b0;
            end
            POST: begin
                if (!wait_q) begin
                    if (cnt_q == CNT_LAST) begin
                        if (POST_FRAMES == 0) state_d = IDLE;
                        else                  wait_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (vs_fall) begin
                    if (frm_q == FRM_LAST) state_d = IDLE;
                    else                   frm_d   = frm_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        blank_d = (state_d == FLUSH) || (state_d == SWITCH) || (state_d == POST);
        busy_d  = (state_d != IDLE);
    end

    assign bus.nEN_YPbPr_o = mode_q;
    assign bus.blank_o     = blank_q;
    assign bus.busy_o      = busy_q;
    assign bus.chg_pulse_o = chg_q;
endmodule
